div_shift_sub: RTL
==================

Name: div_shift_sub

Overview:
- Iterative signed divider for the DPU datapath. It is the inverse of the LUT-only shift-and-add multiplier.
- Computes dividend / divisor using restoring shift-and-subtract, one quotient bit per clock. No DSP and no divider IP, so it stays ASIC-portable.
- Used for requantization and average-pool scaling, where a wide accumulator must be divided by a small INT8 factor.

Parameters:
- DW, 16, dividend and quotient width (signed). Also the number of RUN iterations.
- VW, 8, divisor and remainder width (signed). Must satisfy VW <= DW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  start request; sampled only when busy=0.
- dividend  input  DW  signed dividend; captured on accept.
- divisor  input  VW  signed divisor; captured on accept.
- busy  output  1  high while a division is in flight (RUN or FIX).
- quotient  output  DW  signed quotient, truncated toward zero.
- remainder  output  VW  signed remainder; its sign follows the dividend.
- dbz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  quotient-overflow flag for the last result.
- done  output  1  single-cycle pulse; results are valid from this cycle on.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, iteration counter=0, all outputs=0. Reset overrides everything, including mid-RUN or mid-FIX; the in-flight operation is discarded and no done is issued.
- FSM states: IDLE, RUN, FIX.
  - IDLE to RUN: valid=1 at an edge. On that edge, capture |dividend| and |divisor|, the result sign (dividend sign XOR divisor sign), the dividend sign, and a dbz flag (divisor==0). Clear the partial remainder to 0 and load the counter with DW-1.
  - RUN, per edge: shift the partial remainder (VW+1 bits, unsigned) left by 1 and bring in the dividend MSB. Trial-subtract |divisor|. If the trial result is non-negative, keep it and shift in quotient bit 1; otherwise restore the remainder and shift in 0. Decrement the counter. RUN lasts exactly DW cycles.
  - RUN to FIX: on the edge where counter==0.
  - FIX to IDLE: one cycle. This edge applies sign correction, the dbz and ovf overrides, registers quotient, remainder, dbz and ovf, and sets done=1.
- busy = (state != IDLE).
- Latency: valid accepted at edge E0 gives done=1 in the cycle after edge E0+DW+1, which is 17 clocks for DW=16. Latency is the same for every operand, including divide-by-zero.
- done is high for exactly one cycle. quotient, remainder, dbz and ovf hold their values until the next done or reset.
- valid while busy=1 is ignored; there is no queuing.
- During the done cycle the state is already IDLE, so a valid in that same cycle is accepted. Back-to-back issue interval is DW+2 clocks.
- Sign rules: quotient = -|q| if the result sign is negative, else |q|. remainder = -|r| if the dividend is negative, else |r|. |r| < |divisor| <= 2^(VW-1), so the remainder always fits in VW bits.
- Divide by zero (divisor==0): the RUN cycles still elapse. FIX forces:
  - quotient = +max (0x7FFF) if dividend >= 0, else min (0x8000);
  - remainder = 0, dbz=1, ovf=0.
- Overflow: dividend = -2^(DW-1) with divisor = -1 gives quotient = +max (0x7FFF), remainder = 0, ovf=1.
- In all other cases ovf=0 (unless the optional feature below sets it).
- Width rule: the magnitude of -2^(DW-1) is held in DW+1 bits internally; no truncation is permitted before FIX.

Optional Feature:
- Macro: DIV_SAT_INT8_EN.
- Defined: in FIX, after sign correction, the quotient is clamped to [-128, 127] and sign-extended to DW bits. ovf=1 whenever clamping changed the value. A divide-by-zero result becomes 127 or -128 with dbz=1 and ovf=0. This lets the output feed INT8 activations directly.
- Undefined: the quotient is the full DW-bit value, and ovf is set only by the -2^(DW-1) / -1 case.

Test Plan:
- 1000 / 7 -> quotient=142, remainder=6, dbz=0, ovf=0. done is high exactly 17 clocks after the accepting edge; busy is high for 17 cycles.
- -1000 / 7 -> quotient=-142, remainder=-6. 1000 / -7 -> quotient=-142, remainder=6. -1000 / -7 -> quotient=142, remainder=-6. 0 / -5 -> quotient=0, remainder=0.
- 123 / 0 -> quotient=32767, remainder=0, dbz=1. -5 / 0 -> quotient=-32768, dbz=1. Both take the full 17-cycle latency.
- -32768 / -1 -> quotient=32767, remainder=0, ovf=1. -32768 / 1 -> quotient=-32768, ovf=0. 32767 / -128 -> quotient=-255, remainder=127.
- valid pulsed 3 cycles after accept with different operands -> ignored, original result returned. A new valid in the done cycle -> accepted, second done 18 clocks after the first. rst at RUN iteration 5 -> next cycle busy=0 and all outputs 0, no done ever appears, a fresh valid still works.
- With DIV_SAT_INT8_EN: 1000 / 3 -> quotient=127, ovf=1. -1000 / 3 -> quotient=-128, ovf=1. 300 / 3 -> quotient=100, ovf=0. Without the macro: 1000 / 3 -> quotient=333, remainder=1, ovf=0.

Source files
------------

// File: rtl/div_shift_sub_if.sv
// rtl/div_shift_sub_if.sv - request/result bundle for the iterative signed divider
//
// Signals (master = requester, slave = divider):
//   valid     start request, sampled by the divider only while busy=0
//   dividend  DW-bit signed dividend
//   divisor   VW-bit signed divisor
//   busy      division in flight
//   quotient  DW-bit signed quotient, truncated toward zero
//   remainder VW-bit signed remainder, sign follows the dividend
//   dbz       divide-by-zero flag of the last result
//   ovf       quotient-overflow flag of the last result
//   done      one-cycle pulse marking a new result
interface div_shift_sub_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          valid;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;
    logic          ovf;
    logic          done;

    modport master (
        output valid, dividend, divisor,
        input  busy, quotient, remainder, dbz, ovf, done
    );

    modport slave (
        input  valid, dividend, divisor,
        output busy, quotient, remainder, dbz, ovf, done
    );
endinterface

// File: rtl/div_shift_sub.sv
// rtl/div_shift_sub.sv - restoring shift-and-subtract signed divider, one quotient bit per clock
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset; discards any in-flight division
//   bus  div_shift_sub_if.slave: valid/dividend/divisor in,
//        busy/quotient/remainder/dbz/ovf/done out
//
// Optional build macro DIV_SAT_INT8_EN: clamps the final quotient to
// [-128, 127] (sign-extended to DW bits) and raises ovf when clamping
// changed the value.
module div_shift_sub #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic              clk,
    input  logic              rst,
    div_shift_sub_if.slave    bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic signed [DW:0] Q_MAX  = (DW+1)'(2**(DW-1) - 1);
    localparam logic signed [DW:0] Q8_MAX = (DW+1)'(127);
    localparam logic signed [DW:0] Q8_MIN = (DW+1)'(-128);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dvd;       // |dividend|, shifted out MSB first
    logic [VW-1:0] r_dvs;       // |divisor|; |-2^(VW-1)| still fits unsigned
    logic [VW:0]   r_rem;       // partial remainder
    logic [DW:0]   r_q;         // quotient magnitude; 2^(DW-1) must be representable
    logic          r_qsign;
    logic          r_dsign;
    logic          r_dbz_pend;

    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_remo;
    logic          r_dbz;
    logic          r_ovf;
    logic          r_done;

    logic [VW:0]   w_shift;
    logic [VW+1:0] w_trial;
    logic          w_ge;

    logic signed [DW:0] w_q_signed;
    logic [DW-1:0]      w_fix_q;
    logic [VW-1:0]      w_fix_rem;
    logic               w_fix_ovf;

    // The remainder stays below |divisor| <= 2^(VW-1), so shifting it left
    // within VW+1 bits never loses a set bit.
    assign w_shift = (r_rem << 1) | (VW+1)'(r_dvd[DW-1]);
    assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge    = ~w_trial[VW+1];

    always_comb begin
        w_q_signed = r_qsign ? -r_q : r_q;
        w_fix_rem  = r_dsign ? VW'(-r_rem) : VW'(r_rem);
`ifdef DIV_SAT_INT8_EN
        if (w_q_signed > Q8_MAX) begin
            w_fix_q   = DW'(Q8_MAX);
            w_fix_ovf = 1'b1;
        end else if (w_q_signed < Q8_MIN) begin
            w_fix_q   = DW'(Q8_MIN);
            w_fix_ovf = 1'b1;
        end else begin
            w_fix_q   = DW'(w_q_signed);
            w_fix_ovf = 1'b0;
        end
`else
        // Only -2^(DW-1) / -1 can exceed the positive range.
        if (w_q_signed > Q_MAX) begin
            w_fix_q   = DW'(Q_MAX);
            w_fix_ovf = 1'b1;
        end else begin
            w_fix_q   = DW'(w_q_signed);
            w_fix_ovf = 1'b0;
        end
`endif
        if (r_dbz_pend) begin
`ifdef DIV_SAT_INT8_EN
            w_fix_q = r_dsign ? DW'(Q8_MIN) : DW'(Q8_MAX);
`else
            w_fix_q = r_dsign ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
            w_fix_rem = '0;
            w_fix_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_qsign    <= 1'b0;
            r_dsign    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_quot     <= '0;
            r_remo     <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.valid) begin
                        r_state    <= S_RUN;
                        r_dvd      <= bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
                        r_dvs      <= bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
                        r_qsign    <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        r_dsign    <= bus.dividend[DW-1];
                        r_dbz_pend <= (bus.divisor == '0);
                        r_rem      <= '0;
                        r_q        <= '0;
                        r_cnt      <= CW'(DW-1);
                    end
                end
                S_RUN: begin
                    r_dvd <= r_dvd << 1;
                    r_rem <= w_ge ? w_trial[VW:0] : w_shift;
                    r_q   <= {r_q[DW-1:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_quot  <= w_fix_q;
                    r_remo  <= w_fix_rem;
                    r_dbz   <= r_dbz_pend;
                    r_ovf   <= w_fix_ovf;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;
    assign bus.dbz       = r_dbz;
    assign bus.ovf       = r_ovf;
    assign bus.done      = r_done;
endmodule
